// File: rtl/jt6295_pkg.sv
// rtl/jt6295_pkg.sv - shared types and constants for the ADPCM phrase header fetch
//
// Purpose: state encoding, header/phrase-table geometry and ROM address width
// shared by the header fetcher, its interface and any other ctrl-port client.
// Ports: none (package).

package jt6295_pkg;

  localparam int ADDR_W      = 18;
  localparam int PHRASE_W    = 7;
  localparam int HDR_BYTES   = 6;
  localparam int STRIDE      = 8;
  localparam int STRIDE_LOG2 = 3;

  localparam logic [2:0] LAST_IDX = 3'(HDR_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Byte address of the first header byte of a phrase table entry.
  function automatic logic [ADDR_W-1:0] phrase_base(input logic [PHRASE_W-1:0] phrase);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[STRIDE_LOG2 +: PHRASE_W] = phrase;
    return a;
  endfunction

endpackage

// File: rtl/jt6295_hdr_fetch_if.sv
// rtl/jt6295_hdr_fetch_if.sv - command and ROM control-port bundle of the header fetcher
//
// Purpose: groups the phrase-start command handshake and the ctrl ROM read port.
// Signals:
//   cmd_valid/cmd_ready/cmd_phrase/cmd_mask  phrase-start command handshake
//   ctrl_addr/ctrl_dout/ctrl_ok              control ROM read port
// Modports:
//   master  command source and ROM slot scheduler side
//   slave   header fetcher side

interface jt6295_hdr_fetch_if;
  import jt6295_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [PHRASE_W-1:0] cmd_phrase;
  logic [3:0]          cmd_mask;
  logic [ADDR_W-1:0]   ctrl_addr;
  logic [7:0]          ctrl_dout;
  logic                ctrl_ok;

  modport master (
    output cmd_valid, cmd_phrase, cmd_mask, ctrl_dout, ctrl_ok,
    input  cmd_ready, ctrl_addr
  );

  modport slave (
    input  cmd_valid, cmd_phrase, cmd_mask, ctrl_dout, ctrl_ok,
    output cmd_ready, ctrl_addr
  );

endinterface

// File: rtl/jt6295_settle_cnt.sv
// rtl/jt6295_settle_cnt.sv - guard counter that masks ctrl_ok after an address change
//
// Purpose: after reload, expired stays low for SETTLE cycles, then rises and
// stays high until the next reload.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (counter cleared, expired=1)
//   reload   in   restart the guard window (assert on the ctrl_addr change edge)
//   expired  out  guard window over; ctrl_ok may be trusted

module jt6295_settle_cnt #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (reload) begin
      cnt <= 4'(SETTLE);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = (cnt == 4'd0);

endmodule

// File: rtl/jt6295_hdr_fetch.sv
// rtl/jt6295_hdr_fetch.sv - phrase header fetch and channel address loader
//
// Purpose: accepts a phrase-start command, reads the 6-byte phrase header from
// the ctrl ROM port, assembles 18-bit start/stop addresses and loads them into
// every requested channel that is not busy.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   bus         --   command handshake + ctrl ROM port (slave modport)
//   ch_busy     in   per-channel playing flags, sampled in the load cycle
//   start_addr  out  assembled phrase start address
//   stop_addr   out  assembled phrase stop address
//   ch_load     out  one-cycle per-channel load strobe
//   err         out  one-cycle pulse: phrase 0 or stop < start

module jt6295_hdr_fetch
  import jt6295_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  jt6295_hdr_fetch_if.slave bus,
  input  logic [3:0]        ch_busy,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] stop_addr,
  output logic [3:0]        ch_load,
  output logic              err
);

  state_t     state;
  logic [3:0] mask_q;
  logic [2:0] idx;
  logic [7:0] hdr [HDR_BYTES];

  logic accept;
  logic start_fetch;
  logic capture;
  logic settle_reload;
  logic settle_expired;

  assign accept      = (state == ST_IDLE) & bus.cmd_valid & bus.cmd_ready;
  assign start_fetch = accept & (bus.cmd_phrase != '0) & (bus.cmd_mask != 4'd0);
  assign capture     = (state == ST_FETCH) & settle_expired & bus.ctrl_ok;

  // Every ctrl_addr change restarts the guard window; the last capture does
  // not move the address, so it does not reload.
  assign settle_reload = start_fetch | (capture & (idx != LAST_IDX));

  jt6295_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .reload  (settle_reload),
    .expired (settle_expired)
  );

  // Upper six bits of bytes 0 and 3 are not part of the 18-bit address.
  assign start_addr = {hdr[0][1:0], hdr[1], hdr[2]};
  assign stop_addr  = {hdr[3][1:0], hdr[4], hdr[5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.cmd_ready <= 1'b1;
      bus.ctrl_addr <= '0;
      mask_q        <= 4'd0;
      idx           <= 3'd0;
      ch_load       <= 4'd0;
      err           <= 1'b0;
      for (int i = 0; i < HDR_BYTES; i++) begin
        hdr[i] <= 8'd0;
      end
    end else begin
      ch_load <= 4'd0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mask_q <= bus.cmd_mask;
            if (bus.cmd_phrase == '0) begin
              err <= 1'b1;
            end else if (start_fetch) begin
              bus.ctrl_addr <= phrase_base(bus.cmd_phrase);
              idx           <= 3'd0;
              bus.cmd_ready <= 1'b0;
              state         <= ST_FETCH;
            end
            // an empty mask is accepted and dropped without a fetch
          end
        end
        ST_FETCH: begin
          if (capture) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
              if (idx == 3'(i)) begin
                hdr[i] <= bus.ctrl_dout;
              end
            end
            if (idx == LAST_IDX) begin
              state <= ST_LOAD;
            end else begin
              idx           <= idx + 3'd1;
              bus.ctrl_addr <= bus.ctrl_addr + ADDR_W'(1);
            end
          end
        end
        ST_LOAD: begin
          if (stop_addr >= start_addr) begin
            ch_load <= mask_q & ~ch_busy;
          end else begin
            err <= 1'b1;
          end
          bus.cmd_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          state         <= ST_IDLE;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_hdr_fetch.sv
// tb/tb_jt6295_hdr_fetch.sv - scoreboard bench for the phrase header fetcher

module tb_jt6295_hdr_fetch;

  localparam int SETTLE = 4;
  localparam int FETCH_LAT = 6 * (SETTLE + 1) + 1;

  typedef struct {
    logic [3:0]  ld;
    logic        er;
    bit          chk_addr;
    logic [17:0] sa;
    logic [17:0] sp;
    int          exp_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_busy;
  logic [17:0] start_addr;
  logic [17:0] stop_addr;
  logic [3:0]  ch_load;
  logic        err;

  jt6295_hdr_fetch_if bus ();

  jt6295_hdr_fetch #(.SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ch_busy    (ch_busy),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .ch_load    (ch_load),
    .err        (err)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ok_mode  = 2;   // 0 random ok, 1 ok held high, 2 ok every 8th cycle
  logic [7:0] rom [1024];
  exp_t q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ROM slot scheduler: data is only trustworthy once the address has been
  // stable for SETTLE cycles; before that it returns corrupted bytes.
  logic [17:0] last_addr = '0;
  int          age = 0;
  always @(negedge clk) begin
    logic [7:0] d;
    if (bus.ctrl_addr != last_addr) begin
      last_addr = bus.ctrl_addr;
      age = 0;
    end else if (age < 1000) begin
      age++;
    end
    case (ok_mode)
      0:       bus.ctrl_ok = 1'($urandom_range(0, 1));
      1:       bus.ctrl_ok = 1'b1;
      default: bus.ctrl_ok = ((cyc % 8) == 0);
    endcase
    d = rom[bus.ctrl_addr[9:0]];
    bus.ctrl_dout = (age >= SETTLE) ? d : ~d;
  end

  // Monitor: every visible load strobe or err pulse must match the next
  // expected response.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ch_load != 4'd0 || err)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out ch_load=%b err=%b expected=none", ch_load, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_ch_load", 32'(ch_load), 32'(e.ld));
        chk("mon_err", 32'(err), 32'(e.er));
        if (e.chk_addr) begin
          chk("mon_start", 32'(start_addr), 32'(e.sa));
          chk("mon_stop", 32'(stop_addr), 32'(e.sp));
        end
        if (e.exp_cyc >= 0) chk("mon_latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  task automatic hdr_addrs(input logic [6:0] ph, output logic [17:0] sa, output logic [17:0] sp);
    int base;
    base = int'(ph) * 8;
    sa = 18'((int'(rom[base][1:0]) << 16) + (int'(rom[base+1]) << 8) + int'(rom[base+2]));
    sp = 18'((int'(rom[base+3][1:0]) << 16) + (int'(rom[base+4]) << 8) + int'(rom[base+5]));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) chk("ready_timeout", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input logic [6:0] ph, input logic [3:0] mk,
                         input logic [3:0] ba, input logic [3:0] bb);
    exp_t        e;
    bit          push;
    logic [17:0] sa, sp;
    logic [17:0] prev_addr;
    hdr_addrs(ph, sa, sp);
    push = 1'b0;
    e.chk_addr = 1'b0;
    e.sa = sa;
    e.sp = sp;
    e.ld = 4'd0;
    e.er = 1'b0;
    e.exp_cyc = -1;
    if (ph == 7'd0) begin
      push = 1'b1;
      e.er = 1'b1;
    end else if (mk != 4'd0) begin
      e.chk_addr = 1'b1;
      if (sp >= sa) begin
        e.ld = mk & ~bb;
        push = (e.ld != 4'd0);
      end else begin
        e.er = 1'b1;
        push = 1'b1;
      end
      if (ok_mode == 1) e.exp_cyc = 0;
    end
    wait_ready();
    prev_addr = bus.ctrl_addr;
    if (ph == 7'd0) e.exp_cyc = cyc + 1;
    else if (e.exp_cyc == 0) e.exp_cyc = cyc + 1 + FETCH_LAT;
    if (push) q.push_back(e);
    bus.cmd_valid  = 1'b1;
    bus.cmd_phrase = ph;
    bus.cmd_mask   = mk;
    ch_busy        = ba;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.cmd_phrase = 7'($urandom);
    bus.cmd_mask   = 4'($urandom);
    if (ph == 7'd0 || mk == 4'd0) begin
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
      chk("idle_addr_hold", 32'(bus.ctrl_addr), 32'(prev_addr));
      @(negedge clk);
    end else begin
      chk("fetch_base", 32'(bus.ctrl_addr), 32'(ph) * 8);
      chk("fetch_busy", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      ch_busy = bb;
      wait_ready();
      chk("hold_start", 32'(start_addr), 32'(sa));
      chk("hold_stop", 32'(stop_addr), 32'(sp));
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_phrase = 7'd0;
    bus.cmd_mask = 4'd0;
    ch_busy = 4'd0;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[24] = 8'h01; rom[25] = 8'h23; rom[26] = 8'h45;
    rom[27] = 8'h02; rom[28] = 8'h00; rom[29] = 8'h10;
    rom[32] = 8'h00; rom[33] = 8'h10; rom[34] = 8'h00;
    rom[35] = 8'h00; rom[36] = 8'h0F; rom[37] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_addr", 32'(bus.ctrl_addr), 32'd0);
    chk("rst_start", 32'(start_addr), 32'd0);
    chk("rst_stop", 32'(stop_addr), 32'd0);
    chk("rst_load", 32'(ch_load), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    ok_mode = 2;
    run_cmd(7'd3, 4'b0101, 4'b0000, 4'b0000);
    chk("t1_start", 32'(start_addr), 32'h12345);
    chk("t1_stop", 32'(stop_addr), 32'h20010);
    run_cmd(7'd3, 4'b1111, 4'b0000, 4'b0110);
    run_cmd(7'd0, 4'b1111, 4'b0000, 4'b0000);
    run_cmd(7'd4, 4'b0011, 4'b0000, 4'b0000);
    run_cmd(7'd2, 4'b0000, 4'b0000, 4'b0000);

    ok_mode = 1;
    run_cmd(7'd3, 4'b1010, 4'b0000, 4'b0000);
    run_cmd(7'($urandom_range(1, 127)), 4'b1111, 4'b0000, 4'b0000);

    // Reset after the third captured byte of phrase 9.
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_phrase = 7'd9;
    bus.cmd_mask = 4'b1111;
    ch_busy = 4'd0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.ctrl_addr !== 18'(9 * 8 + 3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach", 32'(bus.ctrl_addr), 32'(9 * 8 + 3));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_addr", 32'(bus.ctrl_addr), 32'd0);
    chk("rst_mid_start", 32'(start_addr), 32'd0);
    chk("rst_mid_stop", 32'(stop_addr), 32'd0);
    chk("rst_mid_load", 32'(ch_load), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    chk("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(7'd5, 4'b0110, 4'b0000, 4'b0000);

    for (int k = 0; k < 40; k++) begin
      logic [6:0] ph;
      ok_mode = int'($urandom_range(0, 2));
      ph = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      run_cmd(ph, 4'($urandom), 4'($urandom), 4'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
